sysp_icb_router: RTL and testbench

SYSP_ICB_ROUTER -- requirements
Module: sysp_icb_router

---
 rtl/sysp_icb_router_pkg.sv | 28 ++
 rtl/sysp_slot_dec.sv | 29 ++
 rtl/sysp_icb_router.sv | 140 ++++++++++++++
 tb/tb_sysp_icb_router.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysp_icb_router_pkg.sv
// ----------------------------------------------------------------------------
// sysp_icb_router_pkg
// Shared definitions for the ICB peripheral-slot router:
//   - FSM state encoding (IDLE / RSP)
//   - default slot-select and per-slot offset widths
//   - the 16-slot peripheral map and the resulting populated-slot mask
// ----------------------------------------------------------------------------
package sysp_icb_router_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RSP  = 1'b1;

    localparam int DEF_SEL_W = 4;
    localparam int DEF_OFS_W = 8;

    localparam int SLOT_UART0  = 0;
    localparam int SLOT_UART1  = 1;
    localparam int SLOT_SPI0   = 2;
    localparam int SLOT_TIMER0 = 3;
    localparam int SLOT_FPIOA  = 15;

    localparam logic [15:0] DEF_SLOT_MAP = (16'h1 << SLOT_UART0)
                                         | (16'h1 << SLOT_UART1)
                                         | (16'h1 << SLOT_SPI0)
                                         | (16'h1 << SLOT_TIMER0)
                                         | (16'h1 << SLOT_FPIOA);

endpackage

// File: rtl/sysp_slot_dec.sv
// ----------------------------------------------------------------------------
// sysp_slot_dec
// Decodes a slot index into a "populated" flag and a one-hot strobe vector.
// The one-hot vector is all zero for unpopulated slots.
// Ports:
//   slot      in  SEL_W      slot index
//   populated out 1          SLOT_MASK[slot]
//   onehot    out 2**SEL_W   one-hot of slot, gated by populated
// ----------------------------------------------------------------------------
module sysp_slot_dec
    import sysp_icb_router_pkg::*;
#(
    parameter int                    SEL_W     = DEF_SEL_W,
    parameter logic [(2**SEL_W)-1:0] SLOT_MASK = DEF_SLOT_MAP
) (
    input  logic [SEL_W-1:0]      slot,
    output logic                  populated,
    output logic [(2**SEL_W)-1:0] onehot
);

    always_comb begin
        populated = SLOT_MASK[slot];
        onehot    = '0;
        if (SLOT_MASK[slot]) begin
            onehot[slot] = 1'b1;
        end
    end

endmodule

// File: rtl/sysp_icb_router.sv
// ----------------------------------------------------------------------------
// sysp_icb_router
// Routes single ICB transactions to one of 2**SEL_W peripheral slots selected
// by addr[OFS_W+SEL_W-1:OFS_W]. One outstanding transaction; response one
// cycle after accept; back-to-back accept during the response handshake.
// Optional feature macro: SYSP_ROUTER_ERR_RSP_EN -- when defined, accesses to
// unpopulated slots answer with icb_rsp_err = 1; otherwise icb_rsp_err is 0.
// Ports:
//   clk, rst                 clock, async active-high reset
//   icb_cmd_*                ICB command channel (valid/ready/addr/read/wdata/wmask)
//   icb_rsp_*                ICB response channel (valid/ready/err/rdata)
//   slot_waddr/slot_raddr    word-aligned offset shared by all slots
//   slot_wdata/slot_sel      write data / byte mask shared by all slots
//   slot_we/slot_rd          one-hot write/read strobes, accept cycle only
//   slot_rdata               packed read data, slot i at [i*DATA_W +: DATA_W]
// ----------------------------------------------------------------------------
module sysp_icb_router
    import sysp_icb_router_pkg::*;
#(
    parameter int                    ADDR_W    = 32,
    parameter int                    DATA_W    = 32,
    parameter int                    SEL_W     = DEF_SEL_W,
    parameter int                    OFS_W     = DEF_OFS_W,
    parameter logic [(2**SEL_W)-1:0] SLOT_MASK = DEF_SLOT_MAP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         icb_cmd_valid,
    output logic                         icb_cmd_ready,
    input  logic [ADDR_W-1:0]            icb_cmd_addr,
    input  logic                         icb_cmd_read,
    input  logic [DATA_W-1:0]            icb_cmd_wdata,
    input  logic [DATA_W/8-1:0]          icb_cmd_wmask,
    output logic                         icb_rsp_valid,
    input  logic                         icb_rsp_ready,
    output logic                         icb_rsp_err,
    output logic [DATA_W-1:0]            icb_rsp_rdata,
    output logic [OFS_W-1:0]             slot_waddr,
    output logic [OFS_W-1:0]             slot_raddr,
    output logic [DATA_W-1:0]            slot_wdata,
    output logic [DATA_W/8-1:0]          slot_sel,
    output logic [(2**SEL_W)-1:0]        slot_we,
    output logic [(2**SEL_W)-1:0]        slot_rd,
    input  logic [(2**SEL_W)*DATA_W-1:0] slot_rdata
);

    localparam int SLOT_N = 2**SEL_W;

    logic [0:0]        state;
    logic              accept;
    logic [SEL_W-1:0]  cmd_slot;
    logic              cmd_pop;
    logic [SLOT_N-1:0] cmd_hit;
    logic [SEL_W-1:0]  rsp_slot;
    logic              rsp_pop;
    logic              rsp_is_read;
    logic              rsp_first;
    logic [DATA_W-1:0] live_rdata;
    logic [DATA_W-1:0] hold_rdata;

    assign cmd_slot      = icb_cmd_addr[OFS_W+SEL_W-1:OFS_W];
    assign icb_rsp_valid = (state == ST_RSP);
    assign icb_cmd_ready = (state == ST_IDLE) || (icb_rsp_valid && icb_rsp_ready);
    // Reset also suppresses strobes combinationally, not just the state.
    assign accept        = icb_cmd_valid && icb_cmd_ready && !rst;

    sysp_slot_dec #(
        .SEL_W     (SEL_W),
        .SLOT_MASK (SLOT_MASK)
    ) u_dec (
        .slot      (cmd_slot),
        .populated (cmd_pop),
        .onehot    (cmd_hit)
    );

    assign slot_we    = (accept && !icb_cmd_read) ? cmd_hit : '0;
    assign slot_rd    = (accept &&  icb_cmd_read) ? cmd_hit : '0;
    assign slot_waddr = {icb_cmd_addr[OFS_W-1:2], 2'b00};
    assign slot_raddr = {icb_cmd_addr[OFS_W-1:2], 2'b00};
    assign slot_wdata = icb_cmd_wdata;
    assign slot_sel   = icb_cmd_wmask;

    // Live data of the responding slot; zero for writes and unpopulated slots.
    always_comb begin
        live_rdata = '0;
        for (int unsigned i = 0; i < SLOT_N; i++) begin
            if (rsp_pop && rsp_is_read && (SEL_W'(i) == rsp_slot)) begin
                live_rdata = slot_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // First RSP cycle passes slot data through; it is frozen in the hold
    // register at the end of that cycle so later slot changes are invisible.
    assign icb_rsp_rdata = rsp_first ? live_rdata : hold_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rsp_first   <= 1'b0;
            rsp_slot    <= '0;
            rsp_pop     <= 1'b0;
            rsp_is_read <= 1'b0;
            hold_rdata  <= '0;
        end else begin
            if (accept) begin
                state       <= ST_RSP;
                rsp_first   <= 1'b1;
                rsp_slot    <= cmd_slot;
                rsp_pop     <= cmd_pop;
                rsp_is_read <= icb_cmd_read;
            end else begin
                rsp_first <= 1'b0;
                if (icb_rsp_valid && icb_rsp_ready) begin
                    state <= ST_IDLE;
                end
            end
            if (rsp_first) begin
                hold_rdata <= live_rdata;
            end
        end
    end

`ifdef SYSP_ROUTER_ERR_RSP_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= !cmd_pop;
        end
    end

    assign icb_rsp_err = err_q;
`else
    assign icb_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sysp_icb_router.sv
// ----------------------------------------------------------------------------
// tb_sysp_icb_router
// Self-checking bench for sysp_icb_router (default parameters).
// Honours SYSP_ROUTER_ERR_RSP_EN for the expected error flag.
// ----------------------------------------------------------------------------
module tb_sysp_icb_router;

`ifdef SYSP_ROUTER_ERR_RSP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         icb_cmd_valid;
    logic         icb_cmd_ready;
    logic [31:0]  icb_cmd_addr;
    logic         icb_cmd_read;
    logic [31:0]  icb_cmd_wdata;
    logic [3:0]   icb_cmd_wmask;
    logic         icb_rsp_valid;
    logic         icb_rsp_ready;
    logic         icb_rsp_err;
    logic [31:0]  icb_rsp_rdata;
    logic [7:0]   slot_waddr;
    logic [7:0]   slot_raddr;
    logic [31:0]  slot_wdata;
    logic [3:0]   slot_sel;
    logic [15:0]  slot_we;
    logic [15:0]  slot_rd;
    logic [511:0] slot_rdata;

    logic [31:0]  mem [16];

    int checks = 0;
    int errors = 0;

    sysp_icb_router dut (
        .clk           (clk),
        .rst           (rst),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_err   (icb_rsp_err),
        .icb_rsp_rdata (icb_rsp_rdata),
        .slot_waddr    (slot_waddr),
        .slot_raddr    (slot_raddr),
        .slot_wdata    (slot_wdata),
        .slot_sel      (slot_sel),
        .slot_we       (slot_we),
        .slot_rd       (slot_rd),
        .slot_rdata    (slot_rdata)
    );

    always_comb begin
        slot_rdata = '0;
        for (int i = 0; i < 16; i++) slot_rdata[i*32 +: 32] = mem[i];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          slot;
        logic [31:0] rval;
        int          waits;
        logic [15:0] exp_we;
        logic [15:0] exp_rd;
        logic [7:0]  exp_ofs;
        logic [31:0] exp_rdata;
        logic        exp_unpop;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rule: the populated slots are UART0, UART1, SPI0, TIMER0, FPIOA.
    function automatic bit model_pop(input int slot);
        return slot inside {0, 1, 2, 3, 15};
    endfunction

    // One complete transaction from an idle, edge-aligned (+1) start point.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic rd,
                           input logic [31:0] wdata, input logic [3:0] wmask, input int waits,
                           input logic [15:0] exp_we, input logic [15:0] exp_rd,
                           input logic [7:0] exp_ofs, input logic [31:0] exp_rdata,
                           input logic exp_err);
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = addr;
        icb_cmd_read  = rd;
        icb_cmd_wdata = wdata;
        icb_cmd_wmask = wmask;
        icb_rsp_ready = 1'b0;
        #1;
        check({tag, " cmd_ready"}, 64'(icb_cmd_ready), 64'(1'b1));
        check({tag, " slot_we"},   64'(slot_we), 64'(exp_we));
        check({tag, " slot_rd"},   64'(slot_rd), 64'(exp_rd));
        check({tag, " waddr"},     64'(slot_waddr), 64'(exp_ofs));
        check({tag, " raddr"},     64'(slot_raddr), 64'(exp_ofs));
        check({tag, " wdata"},     64'(slot_wdata), 64'(wdata));
        check({tag, " sel"},       64'(slot_sel), 64'(wmask));
        tick();
        icb_cmd_valid = 1'b0;
        icb_rsp_ready = (waits == 0);
        #1;
        check({tag, " rsp_valid"}, 64'(icb_rsp_valid), 64'(1'b1));
        check({tag, " rsp_rdata"}, 64'(icb_rsp_rdata), 64'(exp_rdata));
        check({tag, " rsp_err"},   64'(icb_rsp_err), 64'(exp_err));
        check({tag, " no strobe in rsp"}, 64'({slot_we, slot_rd}), 64'(0));
        for (int w = 1; w <= waits; w++) begin
            tick();
            for (int i = 0; i < 16; i++) mem[i] = (w == 1) ? 32'h0000_FFFF : $urandom;
            icb_rsp_ready = (w == waits);
            #1;
            check({tag, " rsp_valid held"}, 64'(icb_rsp_valid), 64'(1'b1));
            check({tag, " rdata held"},     64'(icb_rsp_rdata), 64'(exp_rdata));
            check({tag, " err held"},       64'(icb_rsp_err), 64'(exp_err));
        end
        tick();
        icb_rsp_ready = 1'b0;
        #1;
        check({tag, " rsp done"}, 64'(icb_rsp_valid), 64'(1'b0));
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000_0304, 1'b0, 32'h0000_00A5, 4'hF, 3,  32'h0,         0, 16'h0008, 16'h0000, 8'h04, 32'h0,         1'b0};
        vecs[1] = '{32'h0000_0F08, 1'b1, 32'h0,         4'h0, 15, 32'h0000_1234, 3, 16'h0000, 16'h8000, 8'h08, 32'h0000_1234, 1'b0};
        vecs[2] = '{32'h0000_0500, 1'b1, 32'h0,         4'h0, 5,  32'hDEAD_BEEF, 0, 16'h0000, 16'h0000, 8'h00, 32'h0,         1'b1};
        vecs[3] = '{32'h0000_0107, 1'b1, 32'h0,         4'h0, 1,  32'hCAFE_F00D, 0, 16'h0000, 16'h0002, 8'h04, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{32'h0000_0200, 1'b0, 32'h1234_5678, 4'h0, 2,  32'h0,         0, 16'h0004, 16'h0000, 8'h00, 32'h0,         1'b0};
        vecs[5] = '{32'hFFFF_02FF, 1'b1, 32'h0,         4'h0, 2,  32'h1357_9BDF, 1, 16'h0000, 16'h0004, 8'hFC, 32'h1357_9BDF, 1'b0};
        vecs[6] = '{32'h0000_0E10, 1'b0, 32'h5555_AAAA, 4'h3, 14, 32'h0,         1, 16'h0000, 16'h0000, 8'h10, 32'h0,         1'b1};
        vecs[7] = '{32'h0000_0000, 1'b1, 32'h0,         4'h0, 0,  32'h89AB_CDEF, 2, 16'h0000, 16'h0001, 8'h00, 32'h89AB_CDEF, 1'b0};

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst           = 1'b1;
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = 32'h0000_0100;
        icb_cmd_read  = 1'b1;
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'h0;
        icb_rsp_ready = 1'b0;

        // Reset state, with a command presented that must not strobe.
        tick();
        tick();
        check("reset rsp_valid", 64'(icb_rsp_valid), 64'(1'b0));
        check("reset rsp_err",   64'(icb_rsp_err), 64'(1'b0));
        check("reset rdata",     64'(icb_rsp_rdata), 64'(0));
        check("reset strobes",   64'({slot_we, slot_rd}), 64'(0));
        icb_cmd_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("post-reset cmd_ready", 64'(icb_cmd_ready), 64'(1'b1));
        check("post-reset rsp_valid", 64'(icb_rsp_valid), 64'(1'b0));

        // Directed vector table.
        foreach (vecs[k]) begin
            for (int i = 0; i < 16; i++) mem[i] = $urandom;
            mem[vecs[k].slot] = vecs[k].rval;
            run_txn($sformatf("vec%0d", k), vecs[k].addr, vecs[k].rd, vecs[k].wdata,
                    vecs[k].wmask, vecs[k].waits, vecs[k].exp_we, vecs[k].exp_rd,
                    vecs[k].exp_ofs, vecs[k].exp_rdata, ERR_EN && vecs[k].exp_unpop);
        end

        // Back-to-back reads, slot 0 then slot 1, response ready held high.
        mem[0] = 32'h1111_0000;
        mem[1] = 32'h2222_1111;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = 32'h0000_0000;
        icb_rsp_ready = 1'b1;
        #1;
        check("b2b rd0 strobe", 64'(slot_rd), 64'(16'h0001));
        tick();
        icb_cmd_addr = 32'h0000_0100;
        #1;
        check("b2b rsp0 valid", 64'(icb_rsp_valid), 64'(1'b1));
        check("b2b rsp0 rdata", 64'(icb_rsp_rdata), 64'(32'h1111_0000));
        check("b2b cmd_ready",  64'(icb_cmd_ready), 64'(1'b1));
        check("b2b rd1 strobe", 64'(slot_rd), 64'(16'h0002));
        tick();
        icb_cmd_valid = 1'b0;
        #1;
        check("b2b rsp1 valid", 64'(icb_rsp_valid), 64'(1'b1));
        check("b2b rsp1 rdata", 64'(icb_rsp_rdata), 64'(32'h2222_1111));
        tick();
        icb_rsp_ready = 1'b0;
        #1;
        check("b2b idle", 64'(icb_rsp_valid), 64'(1'b0));

        // Reset while a response is pending and not yet taken.
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = 32'h0000_0104;
        #1;
        tick();
        icb_cmd_valid = 1'b0;
        #1;
        check("rstmid pending", 64'(icb_rsp_valid), 64'(1'b1));
        rst = 1'b1;
        #1;
        check("rstmid valid drop", 64'(icb_rsp_valid), 64'(1'b0));
        check("rstmid cmd_ready",  64'(icb_cmd_ready), 64'(1'b1));
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rstmid no rsp",  64'(icb_rsp_valid), 64'(1'b0));
            check("rstmid ready",   64'(icb_cmd_ready), 64'(1'b1));
        end

        // Randomized transactions against the address-map reference model.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic        r;
            logic [31:0] wd;
            logic [3:0]  wm;
            int          s;
            bit          pop;
            a  = $urandom;
            r  = 1'($urandom_range(0, 1));
            wd = $urandom;
            wm = 4'($urandom_range(0, 15));
            s  = (a / 256) % 16;
            pop = model_pop(s);
            for (int i = 0; i < 16; i++) mem[i] = $urandom;
            run_txn($sformatf("rnd%0d", n), a, r, wd, wm, $urandom_range(0, 3),
                    (pop && !r) ? (16'h1 << s) : 16'h0,
                    (pop &&  r) ? (16'h1 << s) : 16'h0,
                    8'((a % 256) / 4 * 4),
                    (pop && r) ? mem[s] : 32'h0,
                    ERR_EN && !pop);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
